// File: rtl/hazard_filter.sv
// hazard_filter: two-flop synchroniser plus per-bit stability filter for hazard-prone gate-network outputs.
// Latency: a held din change shows on q/rise/fall STABLE+1 edges after it is first sampled (2 sync + STABLE-1).
// No backpressure: en=0 freezes filter state and suppresses pulses; the synchroniser keeps shifting.
module hazard_filter #(
   parameter int WIDTH  = 4,
   parameter int STABLE = 3,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             valid,
   output logic [CNT_W-1:0] glitch_cnt
);

   localparam int CW = $clog2(STABLE + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE - 1);
   localparam int VW = $clog2(STABLE + 3);
   localparam logic [VW-1:0] VLAST = VW'(STABLE + 1);
   localparam int PW = $clog2(WIDTH + 1);
   localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [CNT_W-1:0] GMAX = '1;

   typedef enum logic {IDLE, SETTLE} state_t;

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] q_q, rise_q, fall_q;
   state_t           st_q [WIDTH];
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [VW-1:0]    vcnt_q;
   logic             valid_q;
   logic [CNT_W-1:0] gcnt_q, gcnt_d;
   logic [WIDTH-1:0] reject_d;
   logic [PW-1:0]    pop_d;
   logic [SW-1:0]    sum_d;

   // Synchroniser: always shifts so the sampled view is current when en returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= din;
         s2_q <= s2_q ^ s2_q ^ s1_q;
      end
   end

   // Per-bit filter FSM: qualify a candidate level for STABLE samples, pulse on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            st_q[i]  <= IDLE;
            cnt_q[i] <= '0;
         end
         q_q    <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= '0;
         fall_q <= '0;
         if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
               case (st_q[i])
                  IDLE: begin
                     if (s2_q[i] != q_q[i]) begin
                        if (STABLE == 1) begin
                           q_q[i]    <= s2_q[i];
                           rise_q[i] <= s2_q[i];
                           fall_q[i] <= ~s2_q[i];
                        end else begin
                           st_q[i]  <= SETTLE;
                           cnt_q[i] <= CW'(1);
                        end
                     end
                  end
                  SETTLE: begin
                     if (s2_q[i] != q_q[i]) begin
                        if (cnt_q[i] == LAST) begin
                           q_q[i]    <= s2_q[i];
                           rise_q[i] <= s2_q[i];
                           fall_q[i] <= ~s2_q[i];
                           st_q[i]   <= IDLE;
                           cnt_q[i]  <= '0;
                        end else begin
                           cnt_q[i] <= cnt_q[i] + CW'(1);
                        end
                     end else begin
                        // candidate collapsed before qualifying: a rejected glitch
                        st_q[i]  <= IDLE;
                        cnt_q[i] <= '0;
                     end
                  end
                  default: begin
                     st_q[i]  <= IDLE;
                     cnt_q[i] <= '0;
                  end
               endcase
            end
         end
      end
   end

   // Bits rejecting a candidate this cycle, and how many of them there are.
   always_comb begin
      reject_d = '0;
      pop_d    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         reject_d[i] = en && (st_q[i] == SETTLE) && (s2_q[i] == q_q[i]);
         pop_d       = pop_d + PW'(reject_d[i]);
      end
   end

   // Saturating glitch accumulation; clear takes priority over a same-cycle increment.
   always_comb begin
      sum_d = SW'(gcnt_q) + SW'(pop_d);
      if (clr) begin
         gcnt_d = '0;
      end else if (sum_d > SW'(GMAX)) begin
         gcnt_d = GMAX;
      end else begin
         gcnt_d = sum_d[CNT_W-1:0];
      end
   end

   // Glitch counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcnt_q <= '0;
      end else begin
         gcnt_q <= gcnt_d;
      end
   end

   // Valid rises once the synchroniser and one full qualification window have been filled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vcnt_q  <= '0;
         valid_q <= 1'b0;
      end else if (!valid_q) begin
         if (vcnt_q == VLAST) begin
            valid_q <= 1'b1;
         end else begin
            vcnt_q <= vcnt_q + VW'(1);
         end
      end
   end

   assign q          = q_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign valid      = valid_q;
   assign glitch_cnt = gcnt_q;

endmodule

// File: tb/tb_hazard_filter.sv
// Bench for hazard_filter: directed steps then random din/en/clr/reset against a run-length model.
// Two instances share stimulus: default widths, and CNT_W=2 to reach glitch-count saturation quickly.
// Outputs are sampled on the falling edge; inputs change only on the falling edge.
module tb_hazard_filter;

   localparam int W  = 4;
   localparam int ST = 3;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] din;
   logic         en;
   logic         clr;
   logic [W-1:0] q, rise, fall;
   logic         valid;
   logic [7:0]   glitch_cnt;
   logic [W-1:0] sq, srise, sfall;
   logic         svalid;
   logic [1:0]   sgcnt;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   bit [W-1:0] m_s1, m_s2, m_q, m_rise, m_fall;
   int         m_run [W];
   int         m_g8, m_g2, m_edges;

   hazard_filter #(.WIDTH(W), .STABLE(ST), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr(clr),
      .q(q), .rise(rise), .fall(fall), .valid(valid), .glitch_cnt(glitch_cnt)
   );

   hazard_filter #(.WIDTH(W), .STABLE(ST), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr(clr),
      .q(sq), .rise(srise), .fall(sfall), .valid(svalid), .glitch_cnt(sgcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_s1 = '0; m_s2 = '0; m_q = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_g8 = 0; m_g2 = 0; m_edges = 0;
   endfunction

   // A level is accepted once ST consecutive enabled samples disagree with it;
   // a disagreement run that ends early counts as one rejected glitch.
   function automatic void model_edge();
      bit [W-1:0] nq;
      bit [W-1:0] r;
      bit [W-1:0] f;
      int rej;
      nq = m_q; r = '0; f = '0; rej = 0;
      if (en) begin
         for (int i = 0; i < W; i++) begin
            if (m_s2[i] != m_q[i]) begin
               m_run[i]++;
               if (m_run[i] >= ST) begin
                  nq[i] = m_s2[i];
                  r[i] = m_s2[i];
                  f[i] = ~m_s2[i];
                  m_run[i] = 0;
               end
            end else begin
               if (m_run[i] > 0) rej++;
               m_run[i] = 0;
            end
         end
      end
      m_q = nq; m_rise = r; m_fall = f;
      if (clr) begin
         m_g8 = 0; m_g2 = 0;
      end else begin
         m_g8 = (m_g8 + rej > 255) ? 255 : m_g8 + rej;
         m_g2 = (m_g2 + rej > 3) ? 3 : m_g2 + rej;
      end
      m_s2 = m_s1;
      m_s1 = din;
      if (m_edges < 1000) m_edges++;
   endfunction

   task automatic compare_all();
      chk("q", 32'(q), 32'(m_q));
      chk("rise", 32'(rise), 32'(m_rise));
      chk("fall", 32'(fall), 32'(m_fall));
      chk("valid", 32'(valid), 32'(m_edges >= ST + 2));
      chk("glitch_cnt", 32'(glitch_cnt), 32'(m_g8));
      chk("rise_fall_excl", 32'(rise & fall), 32'(0));
      chk("sat_q", 32'(sq), 32'(m_q));
      chk("sat_rise", 32'(srise), 32'(m_rise));
      chk("sat_valid", 32'(svalid), 32'(m_edges >= ST + 2));
      chk("sat_glitch_cnt", 32'(sgcnt), 32'(m_g2));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      @(negedge clk);
      compare_all();
   endtask

   // Pulse the masked bits high for two cycles, then give the filter time to reject them.
   task automatic glitch(input logic [W-1:0] m);
      din = din | m;
      tick();
      tick();
      din = din & ~m;
      repeat (4) tick();
   endtask

   initial begin
      din = 4'hF; en = 1'b1; clr = 1'b0; rst_n = 1'b0;
      model_reset();

      // reset held with inputs high
      @(negedge clk);
      compare_all();
      chk("rst_q", 32'(q), 32'(0));
      chk("rst_valid", 32'(valid), 32'(0));
      chk("rst_gcnt", 32'(glitch_cnt), 32'(0));
      tick();
      tick();

      // release: valid and the all-ones level arrive on the fifth edge
      rst_n = 1'b1;
      for (int t = 1; t <= 5; t++) begin
         tick();
         chk("valid_edge", 32'(valid), 32'(t >= 5));
      end
      chk("rel_q", 32'(q), 32'(4'hF));
      chk("rel_rise", 32'(rise), 32'(4'hF));
      din = 4'h0;
      repeat (6) tick();

      // clean step on bit 0
      din[0] = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick();
         chk("step_rise0", 32'(rise[0]), 32'(t == 5));
         chk("step_q0", 32'(q[0]), 32'(t >= 5));
         chk("step_fall", 32'(fall), 32'(0));
      end

      // enable dropped mid-qualification on bit 2, then restored
      din[2] = 1'b1;
      repeat (3) tick();
      en = 1'b0;
      for (int t = 0; t < 10; t++) begin
         tick();
         chk("en_hold_q2", 32'(q[2]), 32'(0));
         chk("en_hold_rise", 32'(rise), 32'(0));
      end
      en = 1'b1;
      tick();
      chk("en_resume_q2", 32'(q[2]), 32'(0));
      tick();
      chk("en_resume_rise2", 32'(rise[2]), 32'(1));
      chk("en_resume_q2b", 32'(q[2]), 32'(1));

      din = 4'h0;
      repeat (6) tick();
      chk("clean_gcnt", 32'(glitch_cnt), 32'(0));

      // glitches: single, simultaneous triple, all four (saturates the narrow counter)
      glitch(4'b0100);
      chk("glitch1_gcnt", 32'(glitch_cnt), 32'(1));
      chk("glitch1_q", 32'(q), 32'(0));
      glitch(4'b1011);
      chk("glitch3_gcnt", 32'(glitch_cnt), 32'(4));
      chk("glitch3_sat", 32'(sgcnt), 32'(3));
      glitch(4'b1111);
      chk("glitch4_gcnt", 32'(glitch_cnt), 32'(8));
      chk("glitch4_sat", 32'(sgcnt), 32'(3));

      // clear coinciding with a rejection
      clr = 1'b1;
      glitch(4'b0110);
      clr = 1'b0;
      chk("clr_gcnt", 32'(glitch_cnt), 32'(0));
      chk("clr_sat", 32'(sgcnt), 32'(0));
      glitch(4'b0001);
      chk("post_clr_gcnt", 32'(glitch_cnt), 32'(1));

      // asynchronous reset in the middle of qualifying bit 1
      din[1] = 1'b1;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("arst_q", 32'(q), 32'(0));
      chk("arst_valid", 32'(valid), 32'(0));
      tick();
      tick();
      rst_n = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick();
         chk("arst_rise1", 32'(rise[1]), 32'(t == 5));
      end

      // random phase
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(63) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            compare_all();
            tick();
            rst_n = 1'b1;
         end else begin
            for (int i = 0; i < W; i++)
               if ($urandom_range(3) == 0) din[i] = ~din[i];
            en  = ($urandom_range(9) != 0);
            clr = ($urandom_range(31) == 0);
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
